// File: rtl/g07_pkg.sv
// Shared definitions for the g07 bus: address/data types, the slave-port
// state encoding and the default address windows of the 15 slave ports.
package g07_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } g07_state_e;

  localparam int unsigned G07_NUM_SLAVES = 15;

  // Window of slave 0; the other slaves follow at a fixed stride so that the
  // 13-word windows never overlap.
  localparam addr_t G07_BASE_ADDR  = 64'hfffe7637;
  localparam addr_t G07_LAST_ADDR  = 64'hfffe7643;
  localparam addr_t G07_WIN_STRIDE = 64'h10;

  // First byte address of the window of slave `slv`.
  function automatic addr_t g07_slave_base(input int unsigned slv);
    return G07_BASE_ADDR + addr_t'(slv) * G07_WIN_STRIDE;
  endfunction

  // Last byte address (inclusive) of the window of slave `slv`.
  function automatic addr_t g07_slave_last(input int unsigned slv);
    return G07_LAST_ADDR + addr_t'(slv) * G07_WIN_STRIDE;
  endfunction

endpackage

// File: rtl/g07_slave_store.sv
// Local word store of a g07 slave port: DEPTH x 64-bit, synchronous write,
// registered read port whose output holds until the next read. A read can be
// issued as a clear, which loads zero instead of a stored word.
module g07_slave_store
  import g07_pkg::*;
#(
  parameter int unsigned DEPTH = 13,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  data_t            wdata_i,
  input  logic             re_i,
  input  logic             rclr_i,
  input  logic [IDX_W-1:0] raddr_i,
  output data_t            rdata_o
);

  data_t mem_q [DEPTH];
  data_t rdata_q;

  // Word array: written on the rising edge, cleared by reset.
  // NOTE: the array has a reset, so it maps onto flops rather than a RAM
  // macro; that is what makes "all words read 0 after reset" hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < DEPTH)) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge value regardless of block ordering.
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: loads a word (or zero on a clear) and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      if (rclr_i || (32'(raddr_i) >= DEPTH)) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/g07_slave_port.sv
// g07 slave port: decodes the arbiter address against [BASE_ADDR, LAST_ADDR],
// waits WAIT_ST cycles, performs the store access and signals completion with
// a one-cycle Tdone pulse. A new access needs en to be seen low first.
// Optional feature macro: G07_SLAVE_ERR_EN adds the err port and answers
// out-of-window requests with an error completion instead of ignoring them.
module g07_slave_port
  import g07_pkg::*;
#(
  parameter addr_t       BASE_ADDR = G07_BASE_ADDR,
  parameter addr_t       LAST_ADDR = G07_LAST_ADDR,
  parameter int unsigned WAIT_ST   = 2
) (
  input  logic        sysClk,
  input  logic        Breset,
  input  logic        en,
  input  logic [63:0] addr,
  input  logic        wr,
  input  logic [63:0] SbusIn,
  output logic [63:0] dbus_out,
  output logic        Tdone,
  output logic        busy
`ifdef G07_SLAVE_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned DEPTH     = 32'(LAST_ADDR - BASE_ADDR) + 32'd1;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_ST);
`ifdef G07_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  g07_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  data_t            data_q, data_d;
  logic             oow_q, oow_d;   // current access is an out-of-window error

  logic             in_win;
  logic [IDX_W-1:0] idx_in;
  logic             rd_en, rd_clr, we;
  logic [IDX_W-1:0] rd_idx;

  assign in_win = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
  assign idx_in = IDX_W'(addr - BASE_ADDR);

  // State, wait counter and latched request.
  always_ff @(posedge sysClk or negedge Breset) begin
    if (!Breset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      oow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      oow_q   <= oow_d;
    end
  end

  // Next state, request capture, and the read issued on entry to DONE so the
  // data is on dbus_out in the same cycle as Tdone.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise the
    // paths that do not assign it would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    data_d  = data_q;
    oow_d   = oow_q;
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    rd_idx  = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && (in_win || ERR_EN)) begin
          idx_d  = in_win ? idx_in : '0;
          wr_d   = wr;
          data_d = SbusIn;
          oow_d  = !in_win;
          cnt_d  = WAIT_INIT;
          if (WAIT_ST == 0) begin
            state_d = ST_DONE;
            rd_en   = !wr || !in_win;
            rd_clr  = !in_win;
            rd_idx  = idx_d;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!en) begin
          // Arbiter withdrew the request: abandon without touching the store.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_DONE;
            rd_en   = !wr_q || oow_q;
            rd_clr  = oow_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Only a sampled-low en ends the transfer, so a late en cannot
        // trigger a second completion.
        if (!en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign we    = (state_q == ST_DONE) && wr_q && !oow_q;
  assign Tdone = (state_q == ST_DONE);
  assign busy  = (state_q != ST_IDLE);

  g07_slave_store #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_store (
    .clk     (sysClk),
    .rst_n   (Breset),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (data_q),
    .re_i    (rd_en),
    .rclr_i  (rd_clr),
    .raddr_i (rd_idx),
    .rdata_o (dbus_out)
  );

`ifdef G07_SLAVE_ERR_EN
  logic err_q, err_d;

  // Error flag: set when an out-of-window access completes, cleared by the
  // next accepted in-window access.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && en && in_win) begin
      err_d = 1'b0;
    end else if ((state_d == ST_DONE) && oow_d) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge sysClk or negedge Breset) begin
    if (!Breset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/g07_slave_port.md
# g07_slave_port

Bus-side slave endpoint that sits directly downstream of the g07 arbiter, behind one of its slave ports. It decodes the arbiter-driven 64-bit address against a fixed window. It performs a read or write into a local 64-bit word store after a programmable number of wait states, then returns read data with a single-cycle `Tdone` completion pulse. The arbiter uses that pulse to release the grant. One instance per slave window; up to 15 are instantiated at the top level.

## Interface
Parameters:
- `BASE_ADDR`, 64'hfffe7637, first byte address of the window (inclusive)
- `LAST_ADDR`, 64'hfffe7643, last address of the window (inclusive)
- `WAIT_ST`, 2, wait-state cycles between accept and completion (0..15)
- `DEPTH`, LAST_ADDR-BASE_ADDR+1, derived word count of the store; not overridden

Ports:
- `sysClk`  in  1  system clock; all state on rising edge
- `Breset`  in  1  asynchronous, active-low reset
- `en`  in  1  access request from arbiter; held until `Tdone` is seen
- `addr`  in  64  access address; valid while `en`=1
- `wr`  in  1  1 = write, 0 = read; valid while `en`=1
- `SbusIn`  in  64  write data from the granted master
- `dbus_out`  out  64  read data to the arbiter
- `Tdone`  out  1  one-cycle completion pulse
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  decode-error flag; exists only with `G07_SLAVE_ERR_EN`

## Operation
- FSM states: IDLE, WAIT, DONE, RELEASE.
- **IDLE**
  - If `en`=1 and `addr` is within [BASE_ADDR, LAST_ADDR]:
    - latch `addr-BASE_ADDR` as the index (width clog2(DEPTH)), plus `wr` and `SbusIn`
    - load the wait counter with WAIT_ST
    - go to WAIT, or directly to DONE when WAIT_ST=0
  - If `en`=1 and `addr` is out of window: stay in IDLE and drive nothing (the decode belongs to another slave).
- **WAIT**
  - The counter decrements each cycle.
  - When the counter reaches 1, go to DONE.
  - If `en` drops, the access is aborted: return to IDLE, no write, no `Tdone`.
- **DONE** (exactly one cycle)
  - `Tdone`=1.
  - Write: store[index] <= latched data.
  - Read: `dbus_out` <= store[index].
  - Next state is RELEASE.
- **RELEASE**
  - Wait for `en`=0, then go to IDLE.
  - A new access cannot start until `en` has been low for at least one sampled edge. This prevents double completion when the arbiter clears `en` late.
- `dbus_out` holds the last read value until the next read completes; writes do not change it.
- Read-after-write to the same index returns the new data.

## Timing
- Reset values (Breset=0, asynchronous): state IDLE, `Tdone`=0, `busy`=0, `err`=0, `dbus_out`=0, wait counter 0, all store words 0.
- Latency:
  - `en` sampled high at edge k gives `Tdone` high during cycle k+WAIT_ST+1 (WAIT_ST=0 → k+1).
  - Read data is valid in the same cycle as `Tdone` and remains valid afterwards.
- `Tdone` is never high for two consecutive cycles.
- `busy` rises in the cycle after accept and falls in the cycle after `en` is seen low in RELEASE.
- Reset asserted mid-access: all state clears immediately and any pending write is lost.
- Boundary addresses: BASE_ADDR maps to index 0 and LAST_ADDR to index DEPTH-1; both are accepted. BASE_ADDR-1 and LAST_ADDR+1 are ignored.

## Configuration
- Macro: `G07_SLAVE_ERR_EN`.
- Defined:
  - Adds the `err` port.
  - An out-of-window access with `en`=1 in IDLE goes to DONE after WAIT_ST cycles with `Tdone`=1, `err`=1 and `dbus_out`=0; there is no store access.
  - `err` clears on the next accepted in-window access or on reset.
- Undefined: no `err` port; out-of-window requests are ignored as described above.

## Structure
- Shared package `g07_pkg`: the 64-bit address/data typedefs, the state enum (IDLE/WAIT/DONE/RELEASE, 2 bits), and the default slave window constants for all 15 slaves.
- Sub-module `g07_slave_store`: synchronous-write, registered-read word array (DEPTH×64) with reset-to-zero. The FSM, decode and counter stay in the top module.

## Test plan
- Reset, then write 64'hDEAD_BEEF to 64'hfffe7637 and read it back with WAIT_ST=2 → `Tdone` pulses 3 cycles after each `en` sample; read returns 64'hDEAD_BEEF.
- Write to LAST_ADDR 64'hfffe7643 with 64'h1234, then read BASE_ADDR → reads 0, and LAST_ADDR reads 64'h1234.
- `en` with addr 64'hfffe7644 (out of window): no `Tdone` and `busy`=0 without the macro; with `G07_SLAVE_ERR_EN`, `Tdone`=1, `err`=1, `dbus_out`=0 after WAIT_ST+1 cycles.
- Drop `en` one cycle after accept (WAIT_ST=4) → return to IDLE, no `Tdone`, and a subsequent read shows the store unchanged.
- Hold `en` high 3 cycles past `Tdone` → exactly one `Tdone` pulse; the next access is accepted only after `en` goes low.
- Assert Breset during WAIT of a write of 64'hFF → outputs 0 immediately; after release, a read returns 0.
